// File: rtl/alu_serial_seq_if.sv
// alu_serial_seq_if: request/response bundle for the bit-serial ALU sequencer.
//   master : drives start, src1, src2, ALU_control; observes the result side.
//   slave  : the sequencer; observes the request side, drives ready, done,
//            result, zero, cout, overflow.
interface alu_serial_seq_if #(
   parameter int unsigned WIDTH = 32
) ();
   logic             start;
   logic [WIDTH-1:0] src1;
   logic [WIDTH-1:0] src2;
   logic [3:0]       ALU_control;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             cout;
   logic             overflow;

   modport master (
      output start, src1, src2, ALU_control,
      input  ready, done, result, zero, cout, overflow
   );

   modport slave (
      input  start, src1, src2, ALU_control,
      output ready, done, result, zero, cout, overflow
   );
endinterface

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial ALU. Latches operands and a 4-bit control word on
// an accepted start, evaluates one bit per clock (LSB first) through a single
// slice with a registered carry, then presents result/zero/cout/overflow with a
// one-cycle done pulse.
//   clk   : rising-edge clock
//   rst_n : synchronous, active-low reset
//   bus   : alu_serial_seq_if.slave (start/src1/src2/ALU_control in;
//           ready/done/result/zero/cout/overflow out)
module alu_serial_seq #(
   parameter int unsigned WIDTH = 32
) (
   input logic            clk,
   input logic            rst_n,
   alu_serial_seq_if.slave bus
);
   localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;
   typedef enum logic [1:0] {OpNone, OpAnd, OpOr, OpSum} op_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       ctrl_q, ctrl_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   // Decode the incoming word while idle so the carry can be seeded with
   // B_invert at acceptance; decode the latched word otherwise.
   logic [3:0] ctrl_sel;
   logic       a_inv, b_inv, is_arith, is_addsub, is_slt;
   op_e        op_sel;

   assign ctrl_sel = (state_q == StIdle) ? bus.ALU_control : ctrl_q;

   always_comb begin
      a_inv     = 1'b0;
      b_inv     = 1'b0;
      is_arith  = 1'b0;
      is_addsub = 1'b0;
      is_slt    = 1'b0;
      op_sel    = OpNone;
      case (ctrl_sel)
         4'b0000: op_sel = OpAnd;
         4'b0001: op_sel = OpOr;
         4'b0010: begin op_sel = OpSum; is_arith = 1'b1; is_addsub = 1'b1; end
         4'b0110: begin
            op_sel = OpSum; b_inv = 1'b1; is_arith = 1'b1; is_addsub = 1'b1;
         end
         4'b0111: begin
            op_sel = OpSum; b_inv = 1'b1; is_arith = 1'b1; is_slt = 1'b1;
         end
         4'b1100: begin op_sel = OpAnd; a_inv = 1'b1; b_inv = 1'b1; end
         default: op_sel = OpNone;  // unlisted codes produce a zero result
      endcase
   end

   // One ALU slice operating on the current LSB of the operand shift registers.
   logic             a_bit, b_bit, sum_bit, maj_bit, slice_out, slt_bit, last_bit;
   logic [WIDTH-1:0] shifted_res, final_res;

   always_comb begin
      a_bit   = a_q[0] ^ a_inv;
      b_bit   = b_q[0] ^ b_inv;
      sum_bit = a_bit ^ b_bit ^ carry_q;
      maj_bit = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);
      case (op_sel)
         OpAnd:   slice_out = a_bit & b_bit;
         OpOr:    slice_out = a_bit | b_bit;
         OpSum:   slice_out = is_slt ? 1'b0 : sum_bit;
         default: slice_out = 1'b0;
      endcase
      // Result fills from the top so bit 0 lands in place after WIDTH shifts.
      shifted_res = {slice_out, result_q[WIDTH-1:1]};
      // Sign of the true difference: MSB sum corrected by signed overflow.
      slt_bit     = sum_bit ^ (carry_q ^ maj_bit);
      final_res   = is_slt ? {{(WIDTH-1){1'b0}}, slt_bit} : shifted_res;
   end

   assign last_bit = (cnt_q == CntW'(WIDTH - 1));

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      ctrl_d   = ctrl_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      result_d = result_q;
      zero_d   = zero_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      case (state_q)
         StIdle: begin
            if (bus.start) begin
               a_d      = bus.src1;
               b_d      = bus.src2;
               ctrl_d   = bus.ALU_control;
               cnt_d    = '0;
               carry_d  = b_inv;
               result_d = '0;
               zero_d   = 1'b0;
               cout_d   = 1'b0;
               ovf_d    = 1'b0;
               state_d  = StRun;
            end
         end
         StRun: begin
            a_d      = a_q >> 1;
            b_d      = b_q >> 1;
            carry_d  = maj_bit;
            cnt_d    = cnt_q + CntW'(1);
            result_d = shifted_res;
            if (last_bit) begin
               cnt_d    = '0;
               result_d = final_res;
               zero_d   = (final_res == '0);
               cout_d   = is_arith & maj_bit;
               ovf_d    = is_addsub & (carry_q ^ maj_bit);
               state_d  = StFin;
            end
         end
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         ctrl_q   <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         ctrl_q   <= ctrl_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.ready    = (state_q == StIdle);
   assign bus.done     = (state_q == StFin);
   assign bus.result   = result_q;
   assign bus.zero     = zero_q;
   assign bus.cout     = cout_q;
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_alu_serial_seq.sv
// tb_alu_serial_seq: directed and randomized checks of alu_serial_seq against
// a plain-arithmetic reference model.
module tb_alu_serial_seq;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned BOUND = 4 * WIDTH;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_serial_seq_if #(.WIDTH(WIDTH)) bus ();
   alu_serial_seq #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   logic [WIDTH-1:0] exp_res;
   logic             exp_cout, exp_ovf, exp_zero;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: whole-word arithmetic on the operands.
   function automatic void set_exp(input logic [3:0] c, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
      logic [WIDTH:0] s;
      exp_res  = '0;
      exp_cout = 1'b0;
      exp_ovf  = 1'b0;
      case (c)
         4'b0000: exp_res = a & b;
         4'b0001: exp_res = a | b;
         4'b1100: exp_res = ~(a | b);
         4'b0010: begin
            s        = {1'b0, a} + {1'b0, b};
            exp_res  = s[WIDTH-1:0];
            exp_cout = s[WIDTH];
            exp_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (exp_res[WIDTH-1] != a[WIDTH-1]);
         end
         4'b0110: begin
            s        = {1'b0, a} + {1'b0, ~b} + 1;
            exp_res  = s[WIDTH-1:0];
            exp_cout = s[WIDTH];
            exp_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (exp_res[WIDTH-1] != a[WIDTH-1]);
         end
         4'b0111: begin
            s        = {1'b0, a} + {1'b0, ~b} + 1;
            exp_cout = s[WIDTH];
            exp_res  = ($signed(a) < $signed(b)) ? 1 : 0;
         end
         default: exp_res = '0;
      endcase
      exp_zero = (exp_res == '0);
   endfunction

   task automatic wait_ready(input string tag);
      int g = 0;
      @(negedge clk);
      while (!bus.ready && g < BOUND) begin
         @(negedge clk);
         g++;
      end
      chk({tag, "/ready_wait"}, bus.ready, 1);
   endtask

   // Present a request and return just after the accepting edge.
   task automatic launch(input logic [3:0] c, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input bit hold, input string tag);
      wait_ready(tag);
      bus.start       = 1'b1;
      bus.src1        = a;
      bus.src2        = b;
      bus.ALU_control = c;
      set_exp(c, a, b);
      @(posedge clk);
      #1;
      if (!hold) bus.start = 1'b0;
      chk({tag, "/busy"}, bus.ready, 0);
      chk({tag, "/cleared"}, bus.result, 0);
   endtask

   // Scramble inputs while running; done must rise exactly WIDTH edges after accept.
   task automatic run_to_done(input string tag, input bit noise);
      logic early = 1'b0;
      repeat (WIDTH - 1) begin
         bus.src1        = $urandom;
         bus.src2        = $urandom;
         bus.ALU_control = 4'($urandom);
         if (noise) bus.start = 1'($urandom);
         @(posedge clk);
         #1;
         if (bus.done) early = 1'b1;
      end
      if (noise) bus.start = 1'b0;
      chk({tag, "/early_done"}, early, 0);
      @(posedge clk);
      #1;
      chk({tag, "/done"}, bus.done, 1);
      chk({tag, "/ready_fin"}, bus.ready, 0);
      chk({tag, "/result"}, bus.result, exp_res);
      chk({tag, "/cout"}, bus.cout, exp_cout);
      chk({tag, "/overflow"}, bus.overflow, exp_ovf);
      chk({tag, "/zero"}, bus.zero, exp_zero);
   endtask

   task automatic post(input string tag);
      @(posedge clk);
      #1;
      chk({tag, "/done_drop"}, bus.done, 0);
      chk({tag, "/ready_back"}, bus.ready, 1);
      chk({tag, "/result_hold"}, bus.result, exp_res);
   endtask

   task automatic full_op(input logic [3:0] c, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input string tag);
      launch(c, a, b, 1'b0, tag);
      run_to_done(tag, 1'b1);
      post(tag);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [3:0] codes [6];
      logic [3:0] c;
      logic [WIDTH-1:0] ra, rb;
      logic seen;
      int g;
      codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b0111};

      rst_n           = 1'b0;
      bus.start       = 1'b0;
      bus.src1        = '0;
      bus.src2        = '0;
      bus.ALU_control = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst/ready", bus.ready, 1);
      chk("rst/done", bus.done, 0);
      chk("rst/result", bus.result, 0);
      chk("rst/zero", bus.zero, 0);
      chk("rst/cout", bus.cout, 0);
      chk("rst/overflow", bus.overflow, 0);
      rst_n = 1'b1;

      full_op(4'b0010, 32'h7FFFFFFF, 32'h1, "add_ovf");
      full_op(4'b0110, 32'd5, 32'd5, "sub_eq");
      full_op(4'b0110, 32'd3, 32'd5, "sub_neg");
      full_op(4'b0111, 32'hFFFFFFFF, 32'h1, "slt_neg");
      full_op(4'b0111, 32'h7FFFFFFF, 32'h80000000, "slt_ovf");
      full_op(4'b1100, 32'h0, 32'h0, "nor");
      full_op(4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, "and");
      full_op(4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, "or");
      full_op(4'b1111, 32'h12345678, 32'h9ABCDEF0, "unlisted");

      // Start held high: FIN ignores it, the next op takes operands present at acceptance.
      launch(4'b0010, 32'd100, 32'd23, 1'b1, "held1");
      run_to_done("held1", 1'b0);
      bus.src1        = 32'd9;
      bus.src2        = 32'd4;
      bus.ALU_control = 4'b0110;
      @(posedge clk);
      #1;
      chk("held/idle_after_fin", bus.ready, 1);
      chk("held/done_gone", bus.done, 0);
      set_exp(4'b0110, 32'd9, 32'd4);
      g = 0;
      while (bus.ready && g < 4) begin
         @(posedge clk);
         #1;
         g++;
      end
      chk("held2/accept", bus.ready, 0);
      bus.start = 1'b0;
      run_to_done("held2", 1'b1);
      post("held2");

      // Reset in the middle of a run aborts it.
      launch(4'b0010, 32'h12345678, 32'h0F0F0F0F, 1'b0, "rst_mid");
      repeat (9) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_mid/ready", bus.ready, 1);
      chk("rst_mid/done", bus.done, 0);
      chk("rst_mid/result", bus.result, 0);
      chk("rst_mid/zero", bus.zero, 0);
      chk("rst_mid/cout", bus.cout, 0);
      chk("rst_mid/overflow", bus.overflow, 0);
      rst_n = 1'b1;
      seen  = 1'b0;
      repeat (WIDTH + 2) begin
         @(posedge clk);
         #1;
         if (bus.done) seen = 1'b1;
      end
      chk("rst_mid/no_done", seen, 0);
      full_op(4'b0010, 32'd2, 32'd2, "add_after_rst");

      for (int i = 0; i < 12; i++) begin
         c  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : codes[$urandom_range(0, 5)];
         ra = $urandom;
         rb = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom);
         full_op(c, ra, rb, $sformatf("rand%0d_c%0h", i, c));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
